// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, state
// encodings, datapath select codes and the packed control word.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   localparam logic [1:0] ALUSRCB_B      = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEXE = 4'd9,
      S_JUMP   = 4'd10,
      S_JAL    = 4'd11,
      S_JR     = 4'd12,
      S_IMMWB  = 4'd13,
      S_HALT   = 4'd15
   } mc_state_e;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       ext_op;
      logic       jal_en;
      logic       lui_en;
      logic       instr_done;
      logic       illegal;
   } mc_ctrl_t;

   // Successor of DECODE; FETCH doubles as the "unimplemented opcode" answer.
   function automatic mc_state_e decode_next(input logic [5:0] op, input logic [5:0] fn);
      mc_state_e nxt;
      case (op)
         OP_LW, OP_SW:                           nxt = S_MEMADR;
         OP_RTYPE:                               nxt = (fn == FUNCT_JR) ? S_JR : S_RTEXE;
         OP_BEQ, OP_BNE:                         nxt = S_BRANCH;
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_IMMEXE;
         OP_J:                                   nxt = S_JUMP;
         OP_JAL:                                 nxt = S_JAL;
         default:                                nxt = S_FETCH;
      endcase
      return nxt;
   endfunction

   function automatic logic is_logical_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
   endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit bus: instruction fields and memory ready in, datapath controls out.
// MC_PERF_CNT_EN adds the cycle_cnt/instr_cnt performance counters.
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;

   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCWrite;
   logic       Branch;
   logic       BranchNe;
   logic [1:0] PCSource;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       RegDst;
   logic       MemtoReg;
   logic       RegWrite;
   logic       ExtOp;
   logic       JalEn;
   logic       LuiEn;
   logic [3:0] state_o;
   logic       instr_done;
   logic       illegal;
   logic       bus_fault;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
`endif

   modport master (
      input  opcode, funct, mem_ready,
      output IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, PCSource,
             ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, ExtOp, JalEn, LuiEn,
             state_o, instr_done, illegal, bus_fault
`ifdef MC_PERF_CNT_EN
      , output cycle_cnt, instr_cnt
`endif
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, PCSource,
             ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, ExtOp, JalEn, LuiEn,
             state_o, instr_done, illegal, bus_fault
`ifdef MC_PERF_CNT_EN
      , input cycle_cnt, instr_cnt
`endif
   );
endinterface

// File: rtl/mips_multicycle_control_mem_wait.sv
// Stall counter for memory-access states; flags a timeout once MAX_WAIT stalls
// have elapsed and the memory is still not ready.
module mc_mem_wait #(
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic mem_ready,
   output logic timeout
);
   logic [WAIT_W-1:0] r_cnt;
   logic              w_at_max;

   assign w_at_max = (r_cnt == WAIT_W'(MAX_WAIT));
   // Ready in the cycle the count sits at MAX_WAIT still counts as a completion.
   assign timeout  = !clr && !mem_ready && w_at_max;

   always_ff @(posedge clk) begin
      if (reset || clr || mem_ready) begin
         r_cnt <= '0;
      end else if (!w_at_max) begin
         r_cnt <= r_cnt + WAIT_W'(1);
      end
   end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM driving the shared datapath, with a
// ready/timeout memory handshake. Optional MC_PERF_CNT_EN adds perf counters.
module mips_multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int WAIT_W        = 4,
   parameter int MAX_WAIT      = 8,
   parameter int MEM_HANDSHAKE = 1
) (
   input logic                       clk,
   input logic                       reset,
   mips_multicycle_control_if.master bus
);
   // Handshake: a memory state holds its strobes until mem_ready is seen high
   // at a rising edge, or until the wait counter times out into HALT.
   mc_state_e  r_state;
   mc_state_e  w_next;
   logic [5:0] r_op;
   logic       r_bus_fault;
   mc_ctrl_t   w_ctrl;
   logic       w_ready;
   logic       w_clr;
   logic       w_timeout;
   logic       w_logical;

   assign w_ready   = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;
   assign w_clr     = !((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR));
   assign w_logical = is_logical_imm(r_op);

   mc_mem_wait #(
      .WAIT_W   (WAIT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_mem_wait (
      .clk       (clk),
      .reset     (reset),
      .clr       (w_clr),
      .mem_ready (w_ready),
      .timeout   (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_op        <= '0;
         r_bus_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_op <= bus.opcode;
         if (w_timeout) r_bus_fault <= 1'b1;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_ctrl        = '0;
      w_ctrl.ext_op = 1'b1;
      case (r_state)
         S_FETCH: begin
            w_ctrl.mem_read  = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_FOUR;
            w_ctrl.ir_write  = w_ready;
            w_ctrl.pc_write  = w_ready;
            if (w_timeout) w_next = S_HALT;
            else if (w_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            w_ctrl.alu_src_b = ALUSRCB_IMM_SH;
            w_next           = decode_next(bus.opcode, bus.funct);
            w_ctrl.illegal   = (w_next == S_FETCH);
         end
         S_MEMADR: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_IMM;
            w_next           = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_ctrl.iord     = 1'b1;
            w_ctrl.mem_read = 1'b1;
            if (w_timeout) w_next = S_HALT;
            else if (w_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_ctrl.mem_to_reg = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_MEMWR: begin
            w_ctrl.iord       = 1'b1;
            w_ctrl.mem_write  = 1'b1;
            w_ctrl.instr_done = w_ready;
            if (w_timeout) w_next = S_HALT;
            else if (w_ready) w_next = S_FETCH;
         end
         S_RTEXE: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_op    = ALUOP_FUNCT;
            w_next           = S_ALUWB;
         end
         S_ALUWB: begin
            w_ctrl.reg_dst    = 1'b1;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_BRANCH: begin
            w_ctrl.alu_src_a  = 1'b1;
            w_ctrl.alu_op     = ALUOP_SUB;
            w_ctrl.pc_source  = PCSRC_ALUOUT;
            w_ctrl.branch     = (r_op == OP_BEQ);
            w_ctrl.branch_ne  = (r_op == OP_BNE);
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_IMMEXE: begin
            w_ctrl.alu_src_a = 1'b1;
            w_ctrl.alu_src_b = ALUSRCB_IMM;
            w_ctrl.alu_op    = w_logical ? ALUOP_LOGIC : ALUOP_ADD;
            w_ctrl.ext_op    = !w_logical;
            w_ctrl.lui_en    = (r_op == OP_LUI);
            w_next           = S_IMMWB;
         end
         S_IMMWB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.ext_op     = !w_logical;
            w_ctrl.lui_en     = (r_op == OP_LUI);
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_JUMP: begin
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.pc_source  = PCSRC_JUMP;
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_JAL: begin
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.pc_source  = PCSRC_JUMP;
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.jal_en     = 1'b1;
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_JR: begin
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.pc_source  = PCSRC_REG;
            w_ctrl.instr_done = 1'b1;
            w_next            = S_FETCH;
         end
         S_HALT: begin
            w_ctrl.ext_op = 1'b0;
            w_next        = S_HALT;
         end
         default: w_next = S_FETCH;
      endcase
      // Reset masks every pulse and strobe; only sign extension stays selected.
      if (reset) begin
         w_ctrl        = '0;
         w_ctrl.ext_op = 1'b1;
      end
   end

   assign bus.IorD       = w_ctrl.iord;
   assign bus.MemRead    = w_ctrl.mem_read;
   assign bus.MemWrite   = w_ctrl.mem_write;
   assign bus.IRWrite    = w_ctrl.ir_write;
   assign bus.PCWrite    = w_ctrl.pc_write;
   assign bus.Branch     = w_ctrl.branch;
   assign bus.BranchNe   = w_ctrl.branch_ne;
   assign bus.PCSource   = w_ctrl.pc_source;
   assign bus.ALUSrcA    = w_ctrl.alu_src_a;
   assign bus.ALUSrcB    = w_ctrl.alu_src_b;
   assign bus.ALUOp      = w_ctrl.alu_op;
   assign bus.RegDst     = w_ctrl.reg_dst;
   assign bus.MemtoReg   = w_ctrl.mem_to_reg;
   assign bus.RegWrite   = w_ctrl.reg_write;
   assign bus.ExtOp      = w_ctrl.ext_op;
   assign bus.JalEn      = w_ctrl.jal_en;
   assign bus.LuiEn      = w_ctrl.lui_en;
   assign bus.instr_done = w_ctrl.instr_done;
   assign bus.illegal    = w_ctrl.illegal;
   assign bus.state_o    = reset ? 4'd0 : r_state;
   assign bus.bus_fault  = r_bus_fault && !reset;

`ifdef MC_PERF_CNT_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_cnt <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_ctrl.instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
      end
   end

   assign bus.cycle_cnt = reset ? 32'd0 : r_cycle_cnt;
   assign bus.instr_cnt = reset ? 32'd0 : r_instr_cnt;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_mips_multicycle_control;
   localparam int MAX_WAIT = 8;

   localparam logic [5:0] T_R = 6'h00, T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04;
   localparam logic [5:0] T_BNE = 6'h05, T_ADDI = 6'h08, T_ANDI = 6'h0C, T_ORI = 6'h0D;
   localparam logic [5:0] T_XORI = 6'h0E, T_LUI = 6'h0F, T_LW = 6'h23, T_SW = 6'h2B;

   typedef struct packed {
      logic       iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst, mem_to_reg, reg_write, ext_op, jal_en, lui_en;
      logic       instr_done, illegal, bus_fault;
   } ctl_t;

   typedef struct packed {
      logic [3:0] st;
      logic       rdy;
      ctl_t       c;
   } cyc_t;

   logic clk = 1'b0;
   logic reset;
   cyc_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic m_fault  = 1'b0;

   mips_multicycle_control_if bus ();

   mips_multicycle_control #(
      .WAIT_W        (4),
      .MAX_WAIT      (MAX_WAIT),
      .MEM_HANDSHAKE (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] observe();
      return {5'd0, bus.state_o, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
              bus.PCWrite, bus.Branch, bus.BranchNe, bus.PCSource, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALUOp, bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ExtOp,
              bus.JalEn, bus.LuiEn, bus.instr_done, bus.illegal, bus.bus_fault};
   endfunction

   // ---------------- reference model ----------------
   function automatic ctl_t base();
      ctl_t c = '0;
      c.ext_op    = 1'b1;
      c.bus_fault = m_fault;
      return c;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {T_R, T_J, T_JAL, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_ORI,
                        T_XORI, T_LUI, T_LW, T_SW};
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input ctl_t c);
      cyc_t e;
      e.st = st; e.rdy = rdy; e.c = c;
      exp_q.push_back(e);
   endtask

   // A memory access may stall up to MAX_WAIT cycles; one more stall faults.
   task automatic mem_phase(input logic [3:0] st, input int stall, output logic ok);
      ctl_t c;
      logic rdy;
      ok = 1'b0;
      for (int k = 0; k <= MAX_WAIT && !ok; k++) begin
         rdy = (k == stall);
         c = base();
         if (st == 4'd0) begin
            c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
         end else if (st == 4'd3) begin
            c.iord = 1'b1; c.mem_read = 1'b1;
         end else begin
            c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = rdy;
         end
         push(st, rdy, c);
         ok = rdy;
      end
      if (!ok) begin
         m_fault = 1'b1;
         c = '0;
         c.bus_fault = 1'b1;
         for (int k = 0; k < 3; k++) push(4'd15, 1'($urandom_range(0, 1)), c);
      end
   endtask

   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int sf,
                        input int sm, output logic halted);
      ctl_t c;
      logic ok;
      logic lg;
      halted = 1'b0;
      mem_phase(4'd0, sf, ok);
      if (!ok) begin
         halted = 1'b1;
      end else begin
         c = base(); c.alu_src_b = 2'b11; c.illegal = !is_legal(op);
         push(4'd1, 1'($urandom_range(0, 1)), c);
         if (op == T_LW || op == T_SW) begin
            c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            push(4'd2, 1'($urandom_range(0, 1)), c);
            mem_phase((op == T_LW) ? 4'd3 : 4'd5, sm, ok);
            if (!ok) halted = 1'b1;
            else if (op == T_LW) begin
               c = base(); c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
               push(4'd4, 1'($urandom_range(0, 1)), c);
            end
         end else if (op == T_R && fn == 6'h08) begin
            c = base(); c.pc_write = 1'b1; c.pc_source = 2'b11; c.instr_done = 1'b1;
            push(4'd12, 1'($urandom_range(0, 1)), c);
         end else if (op == T_R) begin
            c = base(); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
            push(4'd6, 1'($urandom_range(0, 1)), c);
            c = base(); c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
            push(4'd7, 1'($urandom_range(0, 1)), c);
         end else if (op == T_BEQ || op == T_BNE) begin
            c = base(); c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
            c.branch = (op == T_BEQ); c.branch_ne = (op == T_BNE); c.instr_done = 1'b1;
            push(4'd8, 1'($urandom_range(0, 1)), c);
         end else if (op inside {T_ADDI, T_ANDI, T_ORI, T_XORI, T_LUI}) begin
            lg = op inside {T_ANDI, T_ORI, T_XORI};
            c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
            c.alu_op = lg ? 2'b11 : 2'b00; c.ext_op = !lg; c.lui_en = (op == T_LUI);
            push(4'd9, 1'($urandom_range(0, 1)), c);
            c = base(); c.reg_write = 1'b1; c.ext_op = !lg; c.lui_en = (op == T_LUI);
            c.instr_done = 1'b1;
            push(4'd13, 1'($urandom_range(0, 1)), c);
         end else if (op == T_J || op == T_JAL) begin
            c = base(); c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
            c.reg_write = (op == T_JAL); c.jal_en = (op == T_JAL);
            push((op == T_J) ? 4'd10 : 4'd11, 1'($urandom_range(0, 1)), c);
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic apply_reset(input int n);
      ctl_t c = '0;
      c.ext_op = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check("reset", observe(), {5'd0, 4'd0, c});
         @(posedge clk); #1;
      end
      reset   = 1'b0;
      m_fault = 1'b0;
   endtask

   // abort_st >= 0: assert reset (with mem_ready high) on reaching that state.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int sf,
                            input int sm, input int abort_st);
      cyc_t e;
      logic halted;
      build(op, fn, sf, sm, halted);
      bus.opcode = op;
      bus.funct  = fn;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (abort_st >= 0 && int'(e.st) == abort_st) begin
            exp_q.delete();
            bus.mem_ready = 1'b1;
            apply_reset(1);
            halted = 1'b0;
         end else begin
            bus.mem_ready = e.rdy;
            @(negedge clk);
            check("cycle", observe(), {5'd0, e.st, e.c});
            @(posedge clk); #1;
         end
      end
      if (halted) apply_reset(2);
   endtask

   logic [5:0] op_tab [13];

   initial begin
      int idx;
      logic [5:0] op;
      logic [5:0] fn;
      int sf;
      int sm;
      op_tab = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_ANDI, T_ORI, T_XORI,
                 T_J, T_JAL, T_LUI, 6'h3F};
      reset         = 1'b1;
      bus.mem_ready = 1'b0;
      bus.opcode    = '0;
      bus.funct     = '0;
      @(posedge clk); #1;
      apply_reset(2);

      run_instr(T_R,   6'h20, 0, 0, -1);
      run_instr(T_LW,  6'h00, 0, 3, -1);
      run_instr(T_BNE, 6'h00, 1, 0, -1);
      run_instr(T_R,   6'h08, 0, 0, -1);
      run_instr(6'h3F, 6'h00, 0, 0, -1);
      run_instr(T_ORI, 6'h00, 0, 0, -1);
      run_instr(T_R,   6'h20, 20, 0, -1);
      run_instr(T_SW,  6'h00, 0, 2, 5);
      run_instr(T_LW,  6'h00, MAX_WAIT, MAX_WAIT, -1);
      run_instr(T_SW,  6'h00, 0, MAX_WAIT + 1, -1);
      run_instr(T_LUI, 6'h00, 0, 0, -1);

      for (int n = 0; n < 250; n++) begin
         idx = $urandom_range(0, 12);
         op  = op_tab[idx];
         if (idx == 12) op = 6'($urandom_range(0, 63));
         fn  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
         sf  = ($urandom_range(0, 19) == 0) ? $urandom_range(MAX_WAIT + 1, 12) : $urandom_range(0, 3);
         sm  = ($urandom_range(0, 19) == 0) ? $urandom_range(MAX_WAIT - 1, 12) : $urandom_range(0, 3);
         run_instr(op, fn, sf, sm, ($urandom_range(0, 29) == 0) ? 5 : -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end
endmodule
